// File: rtl/vga_timing_monitor.sv
// Passive VGA timing checker: recovers pixel/line coordinates and flags timing errors.
// Define VGA_MON_FRAME_CNT_EN to build the locked-frame counter; otherwise frame_cnt is 0.
module vga_timing_monitor #(
  parameter int CLKS_PER_PIXEL = 4,
  parameter int H_TOTAL        = 800,
  parameter int H_SYNC         = 96,
  parameter int H_ACTIVE       = 640,
  parameter int V_TOTAL        = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hSync,
  input  logic        vSync,
  input  logic        bright,
  input  logic        clr_err,
  output logic [9:0]  hc_rx,
  output logic [9:0]  vc_rx,
  output logic        locked,
  output logic [3:0]  err,
  output logic [15:0] frame_cnt
);

  localparam int LCLK_MAX_I = 2 * H_TOTAL * CLKS_PER_PIXEL;
  localparam int CW = $clog2(LCLK_MAX_I + 1);
  localparam int LW = $clog2(2 * V_TOTAL + 1);
  localparam int PW = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;

  localparam logic [CW-1:0] LCLK_MAX   = CW'(LCLK_MAX_I);
  localparam logic [CW-1:0] TOUT_AT    = CW'(LCLK_MAX_I - 1);
  localparam logic [CW-1:0] LINE_LAST  = CW'(H_TOTAL * CLKS_PER_PIXEL - 1);
  localparam logic [CW-1:0] SYNC_CLKS  = CW'(H_SYNC * CLKS_PER_PIXEL);
  localparam logic [CW-1:0] ACT_CLKS   = CW'(H_ACTIVE * CLKS_PER_PIXEL);
  localparam logic [LW-1:0] FRAME_LINES = LW'(V_TOTAL);
  localparam logic [LW-1:0] FRAME_LAST  = LW'(V_TOTAL - 1);
  localparam logic [PW-1:0] PSC_LAST   = PW'(CLKS_PER_PIXEL - 1);
  localparam logic [9:0]    HC_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    VC_LAST    = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t        state, next_state;
  logic          hs_s, vs_s, br_s, hs_d, vs_d;
  logic [CW-1:0] lclk, low_cnt, swid, bcnt;
  logic [LW-1:0] lines;
  logic [PW-1:0] psc;
  logic          primed;
  logic          hs_fall, hs_rise, vs_fall, timeout, frame_bad;
  logic          checking, line_chk;
  logic [3:0]    err_ev;

  // Syncs idle high, so the sample registers reset high to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_s <= 1'b1;
      vs_s <= 1'b1;
      br_s <= 1'b0;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
    end else begin
      hs_s <= hSync;
      vs_s <= vSync;
      br_s <= bright;
      hs_d <= hs_s;
      vs_d <= vs_s;
    end
  end

  assign hs_fall = !hs_s && hs_d;
  assign hs_rise = hs_s && !hs_d;
  assign vs_fall = !vs_s && vs_d;
  assign timeout = !hs_fall && (lclk == TOUT_AT);
  // A line closing in the same cycle as the vSync fall still belongs to the old frame.
  assign frame_bad = hs_fall ? (lines != FRAME_LAST) : (lines != FRAME_LINES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lclk    <= '0;
      low_cnt <= '0;
      swid    <= '0;
      bcnt    <= '0;
      lines   <= '0;
    end else begin
      if (hs_fall)               lclk <= '0;
      else if (lclk != LCLK_MAX) lclk <= lclk + CW'(1);

      if (!hs_s) begin
        if (low_cnt != LCLK_MAX) low_cnt <= low_cnt + CW'(1);
      end else begin
        low_cnt <= '0;
      end
      if (hs_rise) swid <= low_cnt;

      if (hs_fall)                  bcnt <= CW'(br_s);
      else if (br_s && bcnt != '1)  bcnt <= bcnt + CW'(1);

      if (vs_fall)                     lines <= '0;
      else if (hs_fall && lines != '1) lines <= lines + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc   <= '0;
      hc_rx <= '0;
      vc_rx <= '0;
    end else begin
      if (hs_fall) begin
        psc   <= '0;
        hc_rx <= '0;
      end else if (psc == PSC_LAST) begin
        psc   <= '0;
        hc_rx <= (hc_rx == HC_LAST) ? 10'd0 : hc_rx + 10'd1;
      end else begin
        psc <= psc + PW'(1);
      end

      if (vs_fall)      vc_rx <= '0;
      else if (hs_fall) vc_rx <= (vc_rx == VC_LAST) ? 10'd0 : vc_rx + 10'd1;
    end
  end

  // The first line closed after leaving SEARCH only primes the per-line checks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 primed <= 1'b0;
    else if (state == SEARCH) primed <= 1'b0;
    else if (hs_fall)         primed <= 1'b1;
  end

  always_comb begin
    checking  = (state != SEARCH);
    line_chk  = checking && primed && hs_fall;
    err_ev    = '0;
    err_ev[0] = (line_chk && (lclk != LINE_LAST)) || (checking && timeout);
    err_ev[1] = line_chk && (swid != SYNC_CLKS);
    err_ev[2] = checking && vs_fall && frame_bad;
    err_ev[3] = line_chk && (bcnt != '0) && (bcnt != ACT_CLKS);
  end

  always_comb begin
    next_state = state;
    case (state)
      SEARCH: if (vs_fall) next_state = ALIGN;
      ALIGN: begin
        if (err_ev != '0)  next_state = SEARCH;
        else if (vs_fall)  next_state = LOCKED;
      end
      LOCKED: if (err_ev != '0) next_state = SEARCH;
      default: next_state = SEARCH;
    endcase
  end

  // Clearing applies to old flags only; an error raised in the same cycle survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEARCH;
      err   <= '0;
    end else begin
      state <= next_state;
      err   <= (clr_err ? 4'b0000 : err) | ((state == LOCKED) ? err_ev : 4'b0000);
    end
  end

  assign locked = (state == LOCKED);

`ifdef VGA_MON_FRAME_CNT_EN
  logic frame_ok;
  assign frame_ok = (state == LOCKED) && vs_fall && (err_ev == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          frame_cnt <= '0;
    else if (frame_ok) frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a shrunken 20x6-pixel raster, 2 clk per pixel.
module tb_vga_timing_monitor;

  localparam int CPP   = 2;
  localparam int HT    = 20;
  localparam int HS    = 3;
  localparam int HA    = 12;
  localparam int VT    = 6;
  localparam int LINE  = HT * CPP;
  localparam int SYNCW = HS * CPP;
  localparam int BR    = HA * CPP;

`ifdef VGA_MON_FRAME_CNT_EN
  localparam int FC_ON = 1;
`else
  localparam int FC_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        h_sync, v_sync, bright, clr_err;
  logic [9:0]  hc_rx, vc_rx;
  logic        locked;
  logic [3:0]  err;
  logic [15:0] frame_cnt;

  int vectors = 0;
  int miscompares = 0;

  vga_timing_monitor #(
    .CLKS_PER_PIXEL(CPP), .H_TOTAL(HT), .H_SYNC(HS), .H_ACTIVE(HA), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst(rst), .hSync(h_sync), .vSync(v_sync), .bright(bright),
    .clr_err(clr_err), .hc_rx(hc_rx), .vc_rx(vc_rx), .locked(locked),
    .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // One clock of bus activity; outputs are sampled 1 time unit after the edge.
  task automatic apply_stimulus(input logic h, input logic v, input logic b);
    h_sync = h;
    v_sync = v;
    bright = b;
    @(posedge clk);
    #1;
  endtask

  task automatic line_cycle(input int c, input int sync, input int br_len, input bit vs_low);
    apply_stimulus(c >= sync, !vs_low, (c >= sync + 2) && (c < sync + 2 + br_len));
  endtask

  task automatic drive_line(input int period, input int sync, input int br_len, input bit vs_low);
    for (int c = 0; c < period; c++) line_cycle(c, sync, br_len, vs_low);
  endtask

  task automatic nominal_line(input int l);
    drive_line(LINE, SYNCW, (l < 2) ? 0 : BR, l < 2);
  endtask

  task automatic nominal_frame(input int nlines);
    for (int l = 0; l < nlines; l++) nominal_line(l);
  endtask

  // First line of a frame with a one-cycle clr_err pulse on the opening cycle.
  task automatic clear_line0();
    clr_err = 1'b1;
    line_cycle(0, SYNCW, 0, 1'b1);
    clr_err = 1'b0;
    for (int c = 1; c < LINE; c++) line_cycle(c, SYNCW, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    h_sync = 1'b1;
    v_sync = 1'b1;
    bright = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_hc", 16'(hc_rx), 16'd0);
    check_output("reset_vc", 16'(vc_rx), 16'd0);
    check_output("reset_locked", 16'(locked), 16'd0);
    check_output("reset_err", 16'(err), 16'd0);
    check_output("reset_frame_cnt", frame_cnt, 16'd0);
    rst = 1'b1;
    repeat (3) apply_stimulus(1'b1, 1'b1, 1'b0);

    // Acquire lock: SEARCH -> ALIGN -> LOCKED over two vSync falls.
    nominal_frame(VT);
    check_output("f0_locked", 16'(locked), 16'd0);
    nominal_frame(VT);
    check_output("f1_locked", 16'(locked), 16'd1);
    check_output("f1_err", 16'(err), 16'd0);

    // Coordinate recovery in the middle of line 3.
    for (int l = 0; l < 3; l++) nominal_line(l);
    for (int c = 0; c < 12; c++) line_cycle(c, SYNCW, BR, 1'b0);
    check_output("mid_hc", 16'(hc_rx), 16'd5);
    check_output("mid_vc", 16'(vc_rx), 16'd3);
    for (int c = 12; c < LINE; c++) line_cycle(c, SYNCW, BR, 1'b0);
    nominal_line(4);
    nominal_line(5);
    check_output("f2_frame_cnt", frame_cnt, 16'(FC_ON));

    // Stretched line: period error one clock after the closing hSync fall.
    nominal_line(0);
    nominal_line(1);
    drive_line(LINE + 2, SYNCW, BR, 1'b0);
    line_cycle(0, SYNCW, BR, 1'b0);
    check_output("long_locked_pre", 16'(locked), 16'd1);
    line_cycle(1, SYNCW, BR, 1'b0);
    check_output("long_err", 16'(err), 16'b0001);
    check_output("long_locked", 16'(locked), 16'd0);
    check_output("long_hc", 16'(hc_rx), 16'd0);
    for (int c = 2; c < LINE; c++) line_cycle(c, SYNCW, BR, 1'b0);
    nominal_line(4);
    nominal_line(5);
    nominal_frame(VT);
    check_output("relock_f4", 16'(locked), 16'd0);
    nominal_frame(VT);
    check_output("relock_f5", 16'(locked), 16'd1);
    check_output("sticky_err", 16'(err), 16'b0001);

    // clr_err, then a short hSync pulse.
    clear_line0();
    check_output("clr_err", 16'(err), 16'd0);
    nominal_line(1);
    nominal_line(2);
    drive_line(LINE, SYNCW - 1, BR, 1'b0);
    line_cycle(0, SYNCW, BR, 1'b0);
    line_cycle(1, SYNCW, BR, 1'b0);
    check_output("short_sync_err", 16'(err), 16'b0010);
    check_output("short_sync_locked", 16'(locked), 16'd0);
    for (int c = 2; c < LINE; c++) line_cycle(c, SYNCW, BR, 1'b0);
    nominal_line(5);

    // Short bright run while clr_err lands on the same cycle as the new error.
    nominal_frame(VT);
    for (int l = 0; l < 3; l++) nominal_line(l);
    drive_line(LINE, SYNCW, BR - 2, 1'b0);
    line_cycle(0, SYNCW, BR, 1'b0);
    clr_err = 1'b1;
    line_cycle(1, SYNCW, BR, 1'b0);
    clr_err = 1'b0;
    check_output("clr_with_active_err", 16'(err), 16'b1000);
    for (int c = 2; c < LINE; c++) line_cycle(c, SYNCW, BR, 1'b0);
    nominal_line(5);

    // Relock, then stop hSync entirely.
    nominal_frame(VT);
    clear_line0();
    for (int l = 1; l < VT; l++) nominal_line(l);
    check_output("f10_locked", 16'(locked), 16'd1);
    check_output("f10_err", 16'(err), 16'd0);
    nominal_line(0);
    repeat (12) apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("idle_hc_wrap", 16'(hc_rx), 16'd5);
    check_output("idle_vc", 16'(vc_rx), 16'd0);
    repeat (29) apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("timeout_err_pre", 16'(err), 16'd0);
    check_output("timeout_locked_pre", 16'(locked), 16'd1);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("timeout_err", 16'(err), 16'b0001);
    check_output("timeout_locked", 16'(locked), 16'd0);

    // Relock, then a frame one line short.
    nominal_frame(VT);
    clear_line0();
    for (int l = 1; l < VT; l++) nominal_line(l);
    check_output("f13_locked", 16'(locked), 16'd1);
    nominal_frame(VT - 1);
    line_cycle(0, SYNCW, 0, 1'b1);
    line_cycle(1, SYNCW, 0, 1'b1);
    check_output("frame_lines_err", 16'(err), 16'b0100);
    check_output("frame_lines_locked", 16'(locked), 16'd0);
    check_output("frame_cnt_total", frame_cnt, 16'(5 * FC_ON));
    for (int c = 2; c < LINE; c++) line_cycle(c, SYNCW, 0, 1'b1);
    for (int l = 1; l < VT; l++) nominal_line(l);

    // Relock, then reset mid-line.
    nominal_frame(VT);
    nominal_line(0);
    nominal_line(1);
    for (int c = 0; c < 15; c++) line_cycle(c, SYNCW, BR, 1'b0);
    check_output("pre_reset_locked", 16'(locked), 16'd1);
    check_output("pre_reset_err", 16'(err), 16'b0100);
    rst = 1'b0;
    #1;
    check_output("async_reset_hc", 16'(hc_rx), 16'd0);
    check_output("async_reset_vc", 16'(vc_rx), 16'd0);
    check_output("async_reset_locked", 16'(locked), 16'd0);
    check_output("async_reset_err", 16'(err), 16'd0);
    check_output("async_reset_frame_cnt", frame_cnt, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 15; c < LINE; c++) line_cycle(c, SYNCW, BR, 1'b0);
    for (int l = 3; l < VT; l++) nominal_line(l);
    nominal_frame(VT);
    check_output("post_reset_align", 16'(locked), 16'd0);
    nominal_frame(VT);
    check_output("post_reset_locked", 16'(locked), 16'd1);
    check_output("post_reset_err", 16'(err), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_monitor.md
# vga_timing_monitor

Passive sink for the VGA timing bus produced by the display controller. It samples `hSync`, `vSync` and `bright` on the system clock, recovers pixel and line coordinates, and checks line period, sync width, frame height and active width against parameters. It reports lock status and sticky error flags. It sits beside the display/switch/fpsr/board controller stack as an on-chip checker and as a coordinate source for downstream capture logic.

## Interface
- `CLKS_PER_PIXEL`, 4: `clk` cycles per pixel (100 MHz system clock, 25 MHz pixel rate).
- `H_TOTAL`, 800: pixels per line, including blanking.
- `H_SYNC`, 96: `hSync` low width, in pixels.
- `H_ACTIVE`, 640: `bright`-high pixels per visible line.
- `V_TOTAL`, 525: lines per frame.
- `clk` input 1: system clock (ClkPort domain).
- `rst` input 1: reset. Asynchronous, active-low.
- `hSync` input 1: horizontal sync, active-low.
- `vSync` input 1: vertical sync, active-low.
- `bright` input 1: active-video qualifier.
- `clr_err` input 1: single-cycle pulse that clears `err`.
- `hc_rx` output 10: recovered pixel index within the line, 0..H_TOTAL-1.
- `vc_rx` output 10: recovered line index within the frame, 0..V_TOTAL-1.
- `locked` output 1: timing has matched for at least one full frame.
- `err` output 4: sticky error flags.
  - [0] line period / timeout
  - [1] hSync width
  - [2] frame line count
  - [3] active width
- `frame_cnt` output 16: count of locked frames (see Configuration).

## Operation
- **Input sampling.** Inputs are registered once; `*_d` holds the previous sample.
  - A fall is detected when the current sample is 0 and `*_d` is 1.
  - A rise is detected when the current sample is 1 and `*_d` is 0.
- **Counters**
  - `lclk`: clk cycles since the last hSync fall. Saturates at 2·H_TOTAL·CLKS_PER_PIXEL.
  - `swid`: hSync-low cycles, latched on the rise.
  - `bcnt`: bright-high cycles in the current line.
  - `lines`: hSync falls since the last vSync fall.
- **Pixel prescaler.** A prescaler 0..CLKS_PER_PIXEL-1 advances `hc_rx`.
  - On an hSync fall, `hc_rx` and the prescaler load 0.
  - `hc_rx` wraps from H_TOTAL-1 to 0.
  - `vc_rx` increments on each hSync fall and loads 0 on a vSync fall.
- **Per-line checks.** These are evaluated on each hSync fall, except the first one after SEARCH.
  - Period check: lclk+1 ≠ H_TOTAL·CLKS_PER_PIXEL (3200) is a period error.
  - hSync width check: swid ≠ H_SYNC·CLKS_PER_PIXEL (384) is a width error.
  - Active width check: when bcnt ≠ 0 and bcnt ≠ H_ACTIVE·CLKS_PER_PIXEL (2560), an active-width error is raised.
  - Lines with bcnt = 0 are blanking lines and are not checked for active width.
- **Frame check.** On a vSync fall, lines ≠ V_TOTAL is a frame-count error.
- **Timeout.** When lclk reaches its saturation value, a period error is raised.
- **State machine**
  - SEARCH: `locked`=0, checks are suppressed. A vSync fall moves to ALIGN.
  - ALIGN: checks are active, but errors do not set `err`; any mismatch returns to SEARCH. A vSync fall with a clean frame moves to LOCKED.
  - LOCKED: `locked`=1. Any mismatch sets the matching `err` bit and moves to SEARCH.
- **Simultaneous events**
  - If hSync and vSync fall in the same cycle, the line is closed first. That line counts toward `lines`, and then the frame check runs.
  - If `clr_err` coincides with a new error, the new error bit stays set; other bits clear.
- **Reset values** (asynchronous, while `rst`=0): `hc_rx`=0, `vc_rx`=0, `locked`=0, `err`=0, `frame_cnt`=0, all counters 0, state SEARCH. Deasserting reset mid-frame restarts the search.

## Timing
- Edge detection lags the input pin by 2 clk: one input register plus one `*_d` register.
- `hc_rx` is 0 in the cycle after the hSync fall is detected.
- The `err` and `locked` updates are registered: they are visible 1 clk after the detecting edge.
- Lock latency is one full ALIGN frame after the first vSync fall: about 1,680,000 clk plus the partial frame.
- No backpressure; there is no handshake other than the `clr_err` pulse.

## Configuration
- `VGA_MON_FRAME_CNT_EN` defined:
  - `frame_cnt` increments on every vSync fall that passes checks while in LOCKED.
  - It wraps at 16'hFFFF → 0.
  - It clears on reset only.
- Undefined: `frame_cnt` is tied to 0 and the counter logic is omitted.

## Test plan
- Drive nominal 640x480 timing (3200/384/2560 clk, 525 lines) for 3 frames → `locked`=1 after the second vSync fall. `err`=0. `frame_cnt`=1 at the third vSync fall (with the macro).
- While locked, stretch one line to 3204 clk → `err[0]`=1 and `locked`=0 one clk after that hSync fall. Lock is regained after two further clean frames.
- While locked, shorten one hSync pulse to 380 clk → `err[1]`=1. Pulse `clr_err` in the same cycle as a new `err[3]` event → `err`=4'b1000.
- While locked, drop hSync activity entirely → `err[0]`=1 when lclk reaches 6400. `hc_rx` keeps wrapping 0..799.
- Drive a 524-line frame while locked → `err[2]`=1 at the vSync fall. A frame with a 2556-clk bright run → `err[3]`=1.
- Assert `rst`=0 mid-line for 3 clk → all outputs are 0 immediately. After release, lock requires the full SEARCH→ALIGN→LOCKED sequence.
